alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU in the EX stage. It accepts one operation per start pulse and iterates a 32-step shift-add multiply or restoring divide over a shared 33-bit add/subtract path. It owns the HI/LO architectural registers and raises busy so the hazard unit can stall the pipeline while a result is pending.

---
 rtl/alu_muldiv_seq.sv | 156 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_muldiv_seq : sequential MULT/MULTU/DIV/DIVU unit owning HI/LO           |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op_div,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_div;
  logic        r_signed;
  logic        r_res_neg;
  logic        r_rem_neg;
  logic        r_bzero;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_opa;
  logic [63:0] r_acc;

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [32:0] w_add_x;
  logic [32:0] w_add_y;
  logic [32:0] w_sum;
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  assign w_abs_a = (r_signed && r_a[31]) ? (~r_a + 32'd1) : r_a;
  assign w_abs_b = (r_signed && r_b[31]) ? (~r_b + 32'd1) : r_b;

  // One 33-bit adder serves both: multiply adds into the upper half,
  // divide trial-subtracts from the left-shifted remainder.
  assign w_add_x = r_div ? {r_acc[63:32], r_acc[31]} : {1'b0, r_acc[63:32]};
  assign w_add_y = {1'b0, r_opa};
  assign w_sum   = r_div ? (w_add_x - w_add_y) : (w_add_x + w_add_y);

  assign w_prod_fix = r_res_neg ? (~r_acc + 64'd1) : r_acc;
  assign w_quot_fix = r_bzero   ? 32'hFFFF_FFFF
                    : r_res_neg ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
  assign w_rem_fix  = r_rem_neg ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 5'd0;
      r_div     <= 1'b0;
      r_signed  <= 1'b0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_bzero   <= 1'b0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_opa     <= 32'd0;
      r_acc     <= 64'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // FIX only happens while busy, so MTHI/MTLO never collide with it.
      if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (cancel) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (start) begin
              r_div    <= op_div;
              r_signed <= ~sign;
              r_a      <= a;
              r_b      <= b;
              r_bzero  <= (b == 32'd0);
              r_state  <= S_PREP;
              busy     <= 1'b1;
            end else begin
              r_state  <= S_IDLE;
            end
          end
          S_PREP: begin
            r_cnt     <= 5'd0;
            r_res_neg <= r_signed & (r_a[31] ^ r_b[31]);
            r_rem_neg <= r_signed & r_a[31];
            // Low half starts with the operand shifted out during iteration.
            if (r_div) begin
              r_opa <= w_abs_b;
              r_acc <= {32'd0, w_abs_a};
            end else begin
              r_opa <= w_abs_a;
              r_acc <= {32'd0, w_abs_b};
            end
            r_state <= S_CALC;
          end
          S_CALC: begin
            if (r_div) begin
              if (!w_sum[32]) r_acc <= {w_sum[31:0], r_acc[30:0], 1'b1};
              else            r_acc <= {r_acc[62:0], 1'b0};
            end else begin
              if (r_acc[0]) r_acc <= {w_sum, r_acc[31:1]};
              else          r_acc <= {1'b0, r_acc[63:1]};
            end
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= S_FIX;
          end
          S_FIX: begin
            if (r_div) begin
              hi <= w_rem_fix;
              lo <= w_quot_fix;
            end else begin
              hi <= w_prod_fix[63:32];
              lo <= w_prod_fix[31:0];
            end
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_alu_muldiv_seq : scoreboard bench for alu_muldiv_seq                     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, op_div, sign, cancel, hi_we, lo_we;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .sign(sign),
    .a(a), .b(b), .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference: 64-bit native arithmetic.
  function automatic logic [63:0] model(input logic od, input logic sg,
                                        input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, sq, sr;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    if (!od) begin
      if (!sg) return sx * sy;
      return ux * uy;
    end
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!sg) begin
      sq = sx / sy;
      sr = sx % sy;
      return {sr[31:0], sq[31:0]};
    end
    sq = ux / uy;
    sr = ux % uy;
    return {sr[31:0], sq[31:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {63'd0, done}, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e[63:32]});
        chk("lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic drive_start(input logic od, input logic sg, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op_div = od; sign = sg; a = x; b = y;
  endtask

  // Waits for done; optionally pokes start + MTHI while busy.
  task automatic wait_done(input logic disturb, input logic check_busy);
    int  n;
    bit  got;
    n = 0; got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (disturb && i == 6) begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (done) begin got = 1; break; end
      if (busy) n++;
      if (disturb && i == 5) begin
        drive_start(1'b1, 1'b1, 32'd99, 32'd3);
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      end
    end
    start = 1'b0; hi_we = 1'b0;
    if (!got) chk("timeout", 64'd0, 64'd1);
    else if (check_busy) begin
      chk("busy_cycles", 64'(n), 64'd34);
      chk("busy_at_done", {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic run_op(input logic od, input logic sg, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] e, input logic disturb);
    exp_q.push_back(e);
    @(posedge clk); #1;
    drive_start(od, sg, x, y);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    wait_done(disturb, 1'b1);
  endtask

  task automatic mt_write(input logic [31:0] hv, input logic [31:0] lv);
    @(posedge clk); #1; hi_we = 1'b1; wdata = hv;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b1; wdata = lv;
    @(posedge clk); #1; lo_we = 1'b0;
  endtask

  initial begin
    logic        od, sg;
    logic [31:0] x, y;
    bit          saw_done;
    rst = 1'b1; start = 1'b0; op_div = 1'b0; sign = 1'b0; a = 0; b = 0;
    cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    run_op(1'b0, 1'b0, 32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0);
    run_op(1'b1, 1'b1, 32'd100,       32'd0,        64'h0000_0064_FFFF_FFFF, 1'b0);
    run_op(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd0,        64'hFFFF_FF9C_FFFF_FFFF, 1'b0);

    for (int i = 0; i < 10; i++) begin
      od = 1'($urandom); sg = 1'($urandom);
      x = $urandom;
      y = (i == 4) ? 32'd0 : (i[0] ? ($urandom & 32'hFFFF) : $urandom);
      run_op(od, sg, x, y, model(od, sg, x, y), 1'b0);
    end

    // Back-to-back: second start issued in the DONE cycle.
    exp_q.push_back(model(1'b0, 1'b0, 32'd1234, 32'hFFFF_FF00));
    exp_q.push_back(model(1'b1, 1'b1, 32'd1000, 32'd7));
    @(posedge clk); #1;
    drive_start(1'b0, 1'b0, 32'd1234, 32'hFFFF_FF00);
    @(posedge clk); #1; start = 1'b0;
    wait_done(1'b0, 1'b0);
    drive_start(1'b1, 1'b1, 32'd1000, 32'd7);
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done(1'b0, 1'b1);

    // Start and MTHI while busy must be ignored.
    run_op(1'b0, 1'b1, 32'd7, 32'd6, 64'd42, 1'b1);

    mt_write(32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    chk("mt_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    chk("mt_lo", {32'd0, lo}, {32'd0, 32'h9ABC_DEF0});

    @(posedge clk); #1; drive_start(1'b0, 1'b0, 32'd3, 32'd4);
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    @(negedge clk);
    chk("cancel_busy", {63'd0, busy}, 64'd0);
    saw_done = 0;
    repeat (40) begin @(negedge clk); if (done) saw_done = 1; end
    chk("cancel_no_done", {63'd0, saw_done}, 64'd0);
    chk("cancel_hi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    chk("cancel_lo", {32'd0, lo}, {32'd0, 32'h9ABC_DEF0});

    @(posedge clk); #1; drive_start(1'b0, 1'b0, 32'd3, 32'd4);
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("midrst_hi", {32'd0, hi}, 64'd0);
    chk("midrst_lo", {32'd0, lo}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    saw_done = 0;
    repeat (40) begin @(negedge clk); if (done) saw_done = 1; end
    chk("midrst_no_done", {63'd0, saw_done}, 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
